// File: rtl/display_din.sv
// Eight-digit multiplexed seven-segment driver: four hex value digits, three blanks, one keypad digit.
// Define DISPLAY_DIN_LZB_EN to blank leading zeros on value digits 3..1.
module display_din #(
   parameter int CLK_DIV = 50000
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic [15:0] value,
   input  logic [3:0]  num,
   output logic [0:6]  SSeg,
   output logic [7:0]  an
);

   localparam logic [19:0] CNT_LAST = 20'(CLK_DIV - 1);

   logic [19:0] r_cnt;
   logic [2:0]  r_idx;
   logic [7:0]  r_an;
   logic [0:6]  r_sseg;

   logic        w_tick;
   logic [3:0]  w_digit;
   logic        w_blank;
   logic [7:0]  w_an_nxt;
   logic [0:6]  w_seg_nxt;

   // Active-low abcdefg glyphs, a in the leftmost bit.
   function automatic logic [0:6] hex_glyph(input logic [3:0] h);
      case (h)
         4'h0:    hex_glyph = 7'b0000001;
         4'h1:    hex_glyph = 7'b1001111;
         4'h2:    hex_glyph = 7'b0010010;
         4'h3:    hex_glyph = 7'b0000110;
         4'h4:    hex_glyph = 7'b1001100;
         4'h5:    hex_glyph = 7'b0100100;
         4'h6:    hex_glyph = 7'b0100000;
         4'h7:    hex_glyph = 7'b0001111;
         4'h8:    hex_glyph = 7'b0000000;
         4'h9:    hex_glyph = 7'b0000100;
         4'hA:    hex_glyph = 7'b0001000;
         4'hB:    hex_glyph = 7'b1100000;
         4'hC:    hex_glyph = 7'b0110001;
         4'hD:    hex_glyph = 7'b1000010;
         4'hE:    hex_glyph = 7'b0110000;
         4'hF:    hex_glyph = 7'b0111000;
         default: hex_glyph = 7'b1111111;
      endcase
   endfunction

   assign w_tick = (r_cnt == CNT_LAST);

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         r_cnt <= 20'd0;
         r_idx <= 3'd0;
      end else begin
         r_cnt <= w_tick ? 20'd0 : r_cnt + 20'd1;
         r_idx <= w_tick ? r_idx + 3'd1 : r_idx;
      end
   end

   always_comb begin
      w_digit = 4'h0;
      w_blank = 1'b0;
      case (r_idx)
         3'd0: w_digit = value[3:0];
         3'd1: begin
            w_digit = value[7:4];
`ifdef DISPLAY_DIN_LZB_EN
            w_blank = (value[15:4] == 12'h000);
`else
            w_blank = 1'b0;
`endif
         end
         3'd2: begin
            w_digit = value[11:8];
`ifdef DISPLAY_DIN_LZB_EN
            w_blank = (value[15:8] == 8'h00);
`else
            w_blank = 1'b0;
`endif
         end
         3'd3: begin
            w_digit = value[15:12];
`ifdef DISPLAY_DIN_LZB_EN
            w_blank = (value[15:12] == 4'h0);
`else
            w_blank = 1'b0;
`endif
         end
         3'd7:    w_digit = num;
         default: w_blank = 1'b1;
      endcase
   end

   // Anode and segments are both derived from the same index so they switch on one edge.
   assign w_an_nxt  = ~(8'h01 << r_idx);
   assign w_seg_nxt = w_blank ? 7'b1111111 : hex_glyph(w_digit);

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         r_an   <= 8'hFF;
         r_sseg <= 7'b1111111;
      end else begin
         r_an   <= w_an_nxt;
         r_sseg <= w_seg_nxt;
      end
   end

   assign an   = r_an;
   assign SSeg = r_sseg;

endmodule

// File: tb/tb_display_din.sv
// Scoreboard bench for display_din with CLK_DIV=4; expected anode/segment pairs are queued per cycle.
module tb_display_din;

   localparam int CLK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] value = 16'h0000;
   logic [3:0]  num = 4'h0;
   logic [0:6]  sseg;
   logic [7:0]  an;

   int checks = 0;
   int errors = 0;
   logic [14:0] sb[$];

   display_din #(.CLK_DIV(CLK_DIV)) dut (
      .Clk   (clk),
      .reset (rst),
      .value (value),
      .num   (num),
      .SSeg  (sseg),
      .an    (an)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] glyph(input logic [3:0] h);
      logic [6:0] tbl [16];
      tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      return tbl[h];
   endfunction

   function automatic logic [6:0] exp_seg(input int slot, input logic [15:0] v, input logic [3:0] n);
      if (slot == 7) return glyph(n);
      if (slot >= 4) return 7'h7F;
`ifdef DISPLAY_DIN_LZB_EN
      if (slot > 0 && (v >> (4 * slot)) == 16'h0000) return 7'h7F;
`endif
      return glyph(v[slot*4 +: 4]);
   endfunction

   task automatic cmp(input string tag, input logic [7:0] ea, input logic [6:0] es);
      logic [6:0] s;
      s = sseg;
      checks++;
      assert (an === ea) else begin
         errors++;
         $error("FAIL %s an: got %h expected %h", tag, an, ea);
      end
      checks++;
      assert (s === es) else begin
         errors++;
         $error("FAIL %s sseg: got %b expected %b", tag, s, es);
      end
   endtask

   // Queue the expected outputs of one slot, then consume them one clock at a time.
   task automatic run_slot(input int slot, input int ncyc, input int chg_at, input logic [3:0] new_num);
      logic [7:0]  ea;
      logic [14:0] e;
      ea = 8'hFF;
      ea[slot] = 1'b0;
      for (int i = 0; i < ncyc; i++) sb.push_back({ea, exp_seg(slot, value, num)});
      for (int i = 0; i < ncyc; i++) begin
         if (i == chg_at) num = new_num;
         @(posedge clk);
         #1;
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL sb_underflow: got 0 entries expected 1");
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp($sformatf("slot%0d", slot), e[14:7], e[6:0]);
         end
      end
   endtask

   task automatic scan();
      for (int s = 0; s < 8; s++) run_slot(s, CLK_DIV, -1, 4'h0);
   endtask

   initial begin
      #1 rst = 1'b1;
      value = 16'h0305;
      num   = 4'hA;
      #2;
      cmp("reset", 8'hFF, 7'h7F);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Full scan with wrap back to slot 0
      scan();
      run_slot(0, CLK_DIV, -1, 4'h0);
      for (int s = 1; s < 8; s++) run_slot(s, CLK_DIV, -1, 4'h0);

      value = 16'h0000;
      scan();

      for (int d = 0; d < 16; d++) begin
         value = 16'h1230 | 16'(d);
         scan();
      end

      // num changes part-way through slot 3 and must show in slot 7 of the same pass
      num = 4'h1;
      value = 16'hBEEF;
      for (int s = 0; s < 3; s++) run_slot(s, CLK_DIV, -1, 4'h0);
      run_slot(3, CLK_DIV, 2, 4'hF);
      for (int s = 4; s < 8; s++) run_slot(s, CLK_DIV, -1, 4'h0);
      checks++;
      assert (exp_seg(7, value, num) === 7'b0111000) else begin
         errors++;
         $error("FAIL num_model: got %b expected %b", exp_seg(7, value, num), 7'b0111000);
      end

      // Reset in the middle of slot 5
      for (int s = 0; s < 5; s++) run_slot(s, CLK_DIV, -1, 4'h0);
      run_slot(5, 2, -1, 4'h0);
      #3 rst = 1'b1;
      #1;
      cmp("async_reset", 8'hFF, 7'h7F);
      @(posedge clk);
      #1;
      cmp("reset_hold", 8'hFF, 7'h7F);
      @(negedge clk) rst = 1'b0;
      value = 16'h00C7;
      scan();

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL sb_leftover: got %0d expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
